// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encodings, display codes and the per-digit add-3 adjust used by the
// double-dabble datapath.
package bin2bcd_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Digit code the 7-segment decoder renders dark.
  localparam logic [3:0] BLANK_CODE = 4'hF;
  // Digit used to saturate the display on overflow.
  localparam logic [3:0] SAT_DIGIT  = 4'h9;

  // Double-dabble correction: a digit of 5 or more gets +3 before the shift so
  // that doubling it carries correctly into the next decimal digit.
  function automatic logic [3:0] add3_adj(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit combinational add-3 adjust for the double-dabble shifter.
// The result is 4 bits wide; any carry out of the digit is dropped on purpose.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] raw,
  output logic [3:0] adj
);

  assign adj = add3_adj(raw);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// start/busy/done handshake; results beyond DIGITS decimal digits saturate to
// all nines and raise overflow.
// Optional build macro LEADING_ZERO_BLANK_EN: digits above the most significant
// nonzero digit are shown as BLANK_CODE (digit 0 is never blanked, saturated
// results are never blanked).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Counter value seen at the edge that performs the final shift.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [SCR_W-1:0] SAT_WORD = {DIGITS{SAT_DIGIT}};

`ifdef LEADING_ZERO_BLANK_EN
  // Reset display is a blanked zero: F..F0.
  localparam logic [SCR_W-1:0] BCD_RST = {DIGITS{BLANK_CODE}} << 4;
`else
  localparam logic [SCR_W-1:0] BCD_RST = '0;
`endif

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [SCR_W-1:0]   scratch_adj;
  logic [SCR_W-1:0]   result_fmt;

  // Per-digit add-3 correction applied ahead of every shift.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .raw (scratch_q[4*g +: 4]),
      .adj (scratch_adj[4*g +: 4])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Blank every digit above the most significant nonzero one; digit 0 stays.
  always_comb begin
    result_fmt = scratch_q;
    lead_zero  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (scratch_q[4*i +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      if (lead_zero) begin
        result_fmt[4*i +: 4] = BLANK_CODE;
      end
    end
  end
`else
  assign result_fmt = scratch_q;
`endif

  // Next-state logic for the FSM, shift datapath and output registers.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
        // A one leaving the top digit means the value no longer fits.
        sticky_d = sticky_q | scratch_adj[SCR_W-1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        bcd_d   = sticky_q ? SAT_WORD : result_fmt;
        ovf_d   = sticky_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= BCD_RST;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  // The done cycle still counts as busy so the handshake covers the result.
  assign busy     = (state_q != ST_IDLE) | done_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 5-digit and a 4-digit instance,
// compared against a decimal reference model computed with plain arithmetic.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start5, start4;
  logic [15:0] bin5, bin4;
  logic        busy5, busy4, done5, done4, ovf5, ovf4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;

  int vectors;
  int miscompares;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [19:0] RST5 = 20'hFFFF0;
  localparam logic [15:0] RST4 = 16'hFFF0;
`else
  localparam logic [19:0] RST5 = 20'h00000;
  localparam logic [15:0] RST4 = 16'h0000;
`endif

  // Last result each instance should be holding, tracked by the bench.
  logic [19:0] last_bcd [2];
  logic        last_ovf [2];

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start5),
    .bin_in   (bin5),
    .busy     (busy5),
    .done     (done5),
    .bcd_out  (bcd5),
    .overflow (ovf5)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .bin_in   (bin4),
    .busy     (busy4),
    .done     (done4),
    .bcd_out  (bcd4),
    .overflow (ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: decimal digits by repeated division.
  function automatic logic model_ovf(input int unsigned v, input int unsigned digits);
    longint unsigned lim = 1;
    for (int i = 0; i < int'(digits); i++) lim = lim * 10;
    return longint'(v) >= lim;
  endfunction

  function automatic logic [19:0] model_bcd(input int unsigned v, input int unsigned digits);
    logic [19:0] r = '0;
    int unsigned x = v;
    int unsigned nd = 1;
    int unsigned t = v / 10;
    if (model_ovf(v, digits)) begin
      for (int i = 0; i < int'(digits); i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    for (int i = 0; i < int'(digits); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = int'(nd); i < int'(digits); i++) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  // Drive one conversion on instance sel (0: 5 digits, 1: 4 digits) and
  // observe 30 cycles after the accepting edge.
  task automatic convert(input bit sel, input logic [15:0] v,
                         output int done_at, output int busy_cycles, output int pulses,
                         output int unstable, output logic [19:0] res, output logic rovf);
    logic        b, d, o;
    logic [19:0] q;
    done_at = 0; busy_cycles = 0; pulses = 0; unstable = 0; res = '0; rovf = 1'b0;
    @(negedge clk);
    if (sel) begin start4 = 1'b1; bin4 = v; end
    else     begin start5 = 1'b1; bin5 = v; end
    @(posedge clk);
    #1;
    if (sel) begin start4 = 1'b0; bin4 = 16'($urandom); end
    else     begin start5 = 1'b0; bin5 = 16'($urandom); end
    for (int c = 0; c < 30; c++) begin
      b = sel ? busy4 : busy5;
      d = sel ? done4 : done5;
      o = sel ? ovf4 : ovf5;
      q = sel ? {4'h0, bcd4} : bcd5;
      if (b) busy_cycles++;
      if (d) begin
        pulses++;
        if (pulses == 1) begin done_at = c; res = q; rovf = o; end
      end else if (pulses == 0 && (q !== last_bcd[sel] || o !== last_ovf[sel])) begin
        unstable++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_conv(input bit sel, input int unsigned v, input string tag);
    int done_at, busy_cycles, pulses, unstable;
    logic [19:0] res, exp_bcd;
    logic rovf, exp_ovf;
    int unsigned dg;
    dg = sel ? 4 : 5;
    exp_bcd = model_bcd(v, dg);
    exp_ovf = model_ovf(v, dg);
    convert(sel, 16'(v), done_at, busy_cycles, pulses, unstable, res, rovf);
    vectors += 6;
    if (res !== exp_bcd) begin
      miscompares++;
      $display("FAIL %s_bcd d=%0d v=%0d: got %h expected %h", tag, dg, v, res, exp_bcd);
    end
    if (rovf !== exp_ovf) begin
      miscompares++;
      $display("FAIL %s_ovf d=%0d v=%0d: got %b expected %b", tag, dg, v, rovf, exp_ovf);
    end
    if (done_at != 17) begin
      miscompares++;
      $display("FAIL %s_latency v=%0d: done at %0d expected 17", tag, v, done_at);
    end
    if (busy_cycles != 18) begin
      miscompares++;
      $display("FAIL %s_busy v=%0d: busy %0d cycles expected 18", tag, v, busy_cycles);
    end
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL %s_pulses v=%0d: got %0d done pulses expected 1", tag, v, pulses);
    end
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL %s_hold v=%0d: outputs moved %0d times before done expected 0",
               tag, v, unstable);
    end
    last_bcd[sel] = exp_bcd;
    last_ovf[sel] = exp_ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start5 = 1'b0; start4 = 1'b0; bin5 = '0; bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 5;
    if (busy5 !== 1'b0 || done5 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy5, done5);
    end
    if (ovf5 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b expected 0", ovf5);
    end
    if (bcd5 !== RST5) begin
      miscompares++;
      $display("FAIL reset_bcd5: got %h expected %h", bcd5, RST5);
    end
    if (bcd4 !== RST4) begin
      miscompares++;
      $display("FAIL reset_bcd4: got %h expected %h", bcd4, RST4);
    end
    if (busy4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut4_ctrl: busy=%b done=%b ovf=%b expected 0 0 0",
               busy4, done4, ovf4);
    end
    rst_n = 1'b1;
    last_bcd[0] = RST5; last_ovf[0] = 1'b0;
    last_bcd[1] = {4'h0, RST4}; last_ovf[1] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int unsigned vals [8] = '{0, 1234, 65535, 42, 10005, 9999, 1, 10};
    foreach (vals[i]) check_conv(1'b0, vals[i], "dir");
  endtask

  task automatic test_overflow();
    check_conv(1'b1, 12345, "ovf");
    check_conv(1'b1, 9999, "ovf");
    check_conv(1'b1, 10000, "ovf");
    check_conv(1'b1, 0, "ovf");
    check_conv(1'b1, 65535, "ovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      check_conv(1'b0, $urandom_range(0, 65535), "rnd5");
      check_conv(1'b1, (i % 2 == 0) ? $urandom_range(9000, 11000) : $urandom_range(0, 65535),
                 "rnd4");
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] v1;
    logic [19:0] res, exp_bcd;
    logic rovf;
    int pulses;
    v1 = 16'($urandom_range(0, 65535));
    exp_bcd = model_bcd(v1, 5);
    pulses = 0; res = '0; rovf = 1'b0;
    @(negedge clk);
    start5 = 1'b1; bin5 = v1;
    @(posedge clk);
    #1;
    // Hold start high with changing data well into the conversion.
    for (int c = 0; c < 14; c++) begin
      bin5 = v1 ^ 16'($urandom_range(1, 65535));
      @(posedge clk);
      #1;
    end
    start5 = 1'b0;
    for (int m = 0; m < 40; m++) begin
      if (done5) begin
        pulses++;
        if (pulses == 1) begin res = bcd5; rovf = ovf5; end
      end
      // One extra start pulse while the conversion is still finishing.
      if (m == 1) begin start5 = 1'b1; bin5 = ~v1; end
      if (m == 2) start5 = 1'b0;
      @(posedge clk);
      #1;
    end
    vectors += 3;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL ignore_pulses: got %0d done pulses expected 1", pulses);
    end
    if (res !== exp_bcd) begin
      miscompares++;
      $display("FAIL ignore_bcd v=%0d: got %h expected %h", v1, res, exp_bcd);
    end
    if (rovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_ovf: got %b expected 0", rovf);
    end
    last_bcd[0] = exp_bcd; last_ovf[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    check_conv(1'b0, 1234, "pre_rst");
    @(negedge clk);
    start5 = 1'b1; bin5 = 16'd54321;
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (busy5 !== 1'b0 || done5 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl: busy=%b done=%b expected 0 0", busy5, done5);
    end
    if (bcd5 !== RST5) begin
      miscompares++;
      $display("FAIL midrst_bcd: got %h expected %h", bcd5, RST5);
    end
    if (ovf5 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ovf: got %b expected 0", ovf5);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_bcd[0] = RST5; last_ovf[0] = 1'b0;
    last_bcd[1] = {4'h0, RST4}; last_ovf[1] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (done5) pulses++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL midrst_nodone: got %0d done pulses expected 0", pulses);
    end
    check_conv(1'b0, 42, "post_rst");
  endtask

  task automatic test_back_to_back();
    check_conv(1'b0, 65535, "b2b");
    check_conv(1'b0, 0, "b2b");
    check_conv(1'b0, 99999 % 65536, "b2b");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
